// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with 1-cycle logic/arith ops and an iterative shift-add MUL.
// Define ALU_MC_DIV_EN to add the unsigned restoring divider on ctrl 5 (DIVU).
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd5;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
  } sc_res_t;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Unknown codes return all-zero, including the zero flag.
  function automatic sc_res_t alu_single(input logic [3:0]              op,
                                         input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b);
    sc_res_t                 r;
    logic signed [WIDTH-1:0] s;
    logic                    known;
    r     = '0;
    s     = '0;
    known = 1'b1;
    case (op)
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_NOR: r.res = ~(a | b);
      OP_ADD: begin
        s     = a + b;
        r.res = s;
        r.ovf = add_ovf(a, b, s);
      end
      OP_SUB: begin
        s     = a - b;
        r.res = s;
        r.ovf = sub_ovf(a, b, s);
      end
      OP_SLT: r.res = WIDTH'(a < b);
      default: known = 1'b0;
    endcase
    r.zero = known && (r.res == '0);
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [WIDTH:0]   mul_sum;
  logic             is_mul, is_mc, mc_ovf, start_mc;
  sc_res_t          sc;

  assign is_mul   = (ctrl_i == OP_MUL);
  assign start_mc = (state == IDLE) && valid_i && is_mc;
  assign sc       = alu_single(ctrl_i, src1_i, src2_i);

`ifdef ALU_MC_DIV_EN
  logic             is_div;
  logic             op_div, div0;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_take;

  assign is_div = (ctrl_i == OP_DIVU);
  assign is_mc  = is_mul || is_div;

  always_ff @(posedge clk_i) begin
    if (start_mc) begin
      op_div <= is_div;
      div0   <= (src2_i == '0);
    end
  end
`else
  assign is_mc = is_mul;
`endif

  // One iteration per BUSY cycle: shift-add for MUL, restoring step for DIVU.
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    it_hi   = mul_sum[WIDTH:1];
    it_lo   = {mul_sum[0], p_lo[WIDTH-1:1]};
    mc_ovf  = (it_hi != '0);
`ifdef ALU_MC_DIV_EN
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[WIDTH-1:0] - mcand;
    if (op_div) begin
      it_hi  = div_take ? div_diff : div_shift[WIDTH-1:0];
      it_lo  = {p_lo[WIDTH-2:0], div_take};
      mc_ovf = div0;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && is_mc) state_nxt = BUSY;
      end
      BUSY: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand/partial-product registers: loaded at accept, advanced in BUSY.
  always_ff @(posedge clk_i) begin
    if (start_mc) begin
      mcand <= src1_i;
      p_hi  <= '0;
      p_lo  <= src2_i;
`ifdef ALU_MC_DIV_EN
      if (is_div) begin
        mcand <= src2_i;
        p_lo  <= src1_i;
      end
`endif
    end else if (state == BUSY) begin
      p_hi <= it_hi;
      p_lo <= it_lo;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE) begin
        if (valid_i) begin
          if (is_mc) begin
            cnt <= CNT_W'(WIDTH - 1);
          end else begin
            valid_o    <= 1'b1;
            result_o   <= sc.res;
            hi_o       <= '0;
            zero_o     <= sc.zero;
            overflow_o <= sc.ovf;
          end
        end
      end else if (cnt == '0) begin
        valid_o    <= 1'b1;
        result_o   <= it_lo;
        hi_o       <= it_hi;
        zero_o     <= (it_lo == '0);
        overflow_o <= mc_ovf;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): single-cycle op table plus MUL/reset/ctrl-5 sequences.
module tb_alu_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i, src2_i;
  logic        valid_o;
  logic [31:0] result_o, hi_o;
  logic        zero_o, overflow_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .ctrl_i     (ctrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .hi_o       (hi_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b, res;
    logic        zero, ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
  endtask

  // Called just after the accept edge; counts steps until valid_o and BUSY cycles seen.
  task automatic wait_valid(output int n, output int busy);
    n    = 0;
    busy = 0;
    while (!valid_o && n < 100) begin
      if (!ready_o) busy++;
      step();
      n++;
    end
    if (n >= 100) chk("wait_valid_timeout", 64'(n), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_result"}, 64'(result_o), 64'd0);
    chk({tag, "_hi"}, 64'(hi_o), 64'd0);
    chk({tag, "_zero"}, 64'(zero_o), 64'd1);
    chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
  endtask

  initial begin
    int n, busy, pulses;

    vecs[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{4'd12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[4]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[5]  = '{4'd1,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[7]  = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{4'd9,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{4'd2,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};

    rst_i   = 1'b0;
    valid_i = 1'b0;
    ctrl_i  = 4'd0;
    src1_i  = '0;
    src2_i  = '0;
    repeat (3) step();
    chk_reset_vals("in_reset");
    rst_i = 1'b1;
    step();
    chk_reset_vals("after_reset");

    // Back-to-back single-cycle ops
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'd1);
      chk($sformatf("vec%0d_ready", i), 64'(ready_o), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(result_o), 64'(vecs[i].res));
      chk($sformatf("vec%0d_hi", i), 64'(hi_o), 64'd0);
      chk($sformatf("vec%0d_zero", i), 64'(zero_o), 64'(vecs[i].zero));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow_o), 64'(vecs[i].ovf));
    end
    valid_i = 1'b0;
    step();
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("hold_result", 64'(result_o), 64'h7);

    // MUL all-ones squared
    issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    valid_i = 1'b0;
    wait_valid(n, busy);
    chk("mul_ff_busy_cycles", 64'(busy), 64'd32);
    chk("mul_ff_latency_edges", 64'(n + 1), 64'd33);
    chk("mul_ff_ready", 64'(ready_o), 64'd1);
    chk("mul_ff_result", 64'(result_o), 64'h00000001);
    chk("mul_ff_hi", 64'(hi_o), 64'hFFFFFFFE);
    chk("mul_ff_ovf", 64'(overflow_o), 64'd1);
    chk("mul_ff_zero", 64'(zero_o), 64'd0);
    step();
    chk("mul_ff_pulse", 64'(valid_o), 64'd0);
    chk("mul_ff_hold_hi", 64'(hi_o), 64'hFFFFFFFE);

    // MUL 6*7 with an ADD held on valid_i and operands changed during BUSY
    issue(4'd3, 32'd6, 32'd7);
    step();
    issue(4'd2, 32'd10, 32'd20);
    wait_valid(n, busy);
    chk("mul67_busy_cycles", 64'(busy), 64'd32);
    chk("mul67_result", 64'(result_o), 64'd42);
    chk("mul67_hi", 64'(hi_o), 64'd0);
    chk("mul67_ovf", 64'(overflow_o), 64'd0);
    chk("mul67_ready", 64'(ready_o), 64'd1);
    step();
    valid_i = 1'b0;
    chk("add_after_mul_valid", 64'(valid_o), 64'd1);
    chk("add_after_mul_result", 64'(result_o), 64'd30);
    chk("add_after_mul_hi", 64'(hi_o), 64'd0);
    step();
    chk("add_after_mul_single", 64'(valid_o), 64'd0);

    // Reset at BUSY cycle 10 of a MUL
    issue(4'd3, 32'd3, 32'd5);
    step();
    valid_i = 1'b0;
    repeat (9) step();
    chk("pre_abort_ready", 64'(ready_o), 64'd0);
    rst_i = 1'b0;
    #1;
    chk_reset_vals("abort");
    step();
    rst_i  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("abort_no_valid", 64'(pulses), 64'd0);
    chk_reset_vals("abort_settled");
    issue(4'd3, 32'd3, 32'd5);
    step();
    valid_i = 1'b0;
    wait_valid(n, busy);
    chk("post_abort_mul_latency_edges", 64'(n + 1), 64'd33);
    chk("post_abort_mul_result", 64'(result_o), 64'd15);
    chk("post_abort_mul_hi", 64'(hi_o), 64'd0);

`ifdef ALU_MC_DIV_EN
    issue(4'd5, 32'd100, 32'd7);
    step();
    valid_i = 1'b0;
    wait_valid(n, busy);
    chk("divu_latency_edges", 64'(n + 1), 64'd33);
    chk("divu_quot", 64'(result_o), 64'd14);
    chk("divu_rem", 64'(hi_o), 64'd2);
    chk("divu_ovf", 64'(overflow_o), 64'd0);
    issue(4'd5, 32'd9, 32'd0);
    step();
    valid_i = 1'b0;
    wait_valid(n, busy);
    chk("divu0_latency_edges", 64'(n + 1), 64'd33);
    chk("divu0_quot", 64'(result_o), 64'hFFFFFFFF);
    chk("divu0_rem", 64'(hi_o), 64'd9);
    chk("divu0_ovf", 64'(overflow_o), 64'd1);
`else
    // Load nonzero outputs first so the ctrl-5 clearing is visible
    issue(4'd3, 32'h00010000, 32'h00010000);
    step();
    valid_i = 1'b0;
    wait_valid(n, busy);
    chk("pre_ctrl5_hi", 64'(hi_o), 64'd1);
    issue(4'd5, 32'd100, 32'd7);
    step();
    valid_i = 1'b0;
    chk("ctrl5_valid", 64'(valid_o), 64'd1);
    chk("ctrl5_ready", 64'(ready_o), 64'd1);
    chk("ctrl5_result", 64'(result_o), 64'd0);
    chk("ctrl5_hi", 64'(hi_o), 64'd0);
    chk("ctrl5_ovf", 64'(overflow_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle datapath ALU.
- Keeps the existing ctrl encoding for logic, add/sub and SLT ops, with a 1-cycle registered result.
- Adds an iterative shift-add multiply with a 2*WIDTH-bit product and registered zero/overflow flags.
- Uses a valid/ready handshake so the CPU execute stage can stall on multi-cycle ops.

Parameters:
- WIDTH, 32: operand/result width; legal range 8..64.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- ctrl_i  input  4  op select.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- valid_o  output  1  one-cycle pulse: result_o, hi_o and the flags are updated this cycle.
- result_o  output  WIDTH  result (MUL: low half of the product).
- hi_o  output  WIDTH  MUL: high half of the product; other ops: 0.
- zero_o  output  1  high when result_o == 0.
- overflow_o  output  1  overflow flag.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state = IDLE, counter = 0.
  - ready_o = 1, valid_o = 0.
  - result_o = 0, hi_o = 0, zero_o = 1, overflow_o = 0.
- Accept: on a clock edge where valid_i && ready_o. Operands and ctrl are captured at that edge.
- ctrl encoding:
  - 0 AND; 1 OR; 2 ADD; 6 SUB; 12 NOR.
  - 7 SLT: signed compare; result 1 if A < B, else 0.
  - 3 MUL: unsigned, multi-cycle.
  - Any other code: result 0, flags 0, 1-cycle latency.
- Single-cycle ops stay in IDLE:
  - Outputs register at the accept edge; valid_o is high in the following cycle.
  - ready_o stays 1, so a new op can be accepted every cycle (throughput 1/cycle).
- MUL:
  - IDLE -> BUSY at the accept edge; ready_o = 0 while in BUSY.
  - BUSY lasts exactly WIDTH cycles, one shift-add iteration per cycle; the counter counts WIDTH-1 down to 0.
  - On the edge where counter == 0: result_o/hi_o are written, valid_o = 1, state -> IDLE, ready_o = 1.
  - Latency is WIDTH+1 edges from accept to the valid_o cycle. A new op may be accepted in the valid_o cycle.
- Arithmetic:
  - ADD/SUB are WIDTH-bit, wrapping modulo 2^WIDTH.
  - ADD/SUB overflow_o = two's-complement signed overflow.
  - MUL overflow_o = (hi_o != 0).
  - AND/OR/NOR/SLT: overflow_o = 0.
  - zero_o = (result_o == 0), registered together with result_o.
- Hold:
  - result_o, hi_o and the flags hold their last values until the next valid_o.
  - valid_o is a pulse with no backpressure; the consumer must sample it.
- Stall/ignore:
  - valid_i while in BUSY is ignored; no queueing.
  - Operand changes during BUSY have no effect.
- Reset mid-MUL: the operation is aborted, no valid_o is produced, and all outputs take their reset values.
- Flags and hi_o are never X after reset.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: ctrl 5 = DIVU, unsigned restoring division.
  - Same BUSY timing as MUL: WIDTH+1 latency.
  - result_o = quotient, hi_o = remainder, overflow_o = 0.
  - Divide-by-zero: quotient = all ones, remainder = src1, overflow_o = 1, same latency.
- Not defined: ctrl 5 is treated as an unknown code (result 0, flags 0, 1-cycle latency, hi_o = 0) and no divider logic is present.

Test Plan:
- Reset then idle (WIDTH=32): hold rst_i low, release.
  - Required: ready_o=1, valid_o=0, result_o=0, zero_o=1, overflow_o=0.
- Back-to-back single-cycle ops on consecutive cycles: ADD 0x7FFFFFFF+1, SUB 5-5, SLT 0xFFFFFFFF vs 1, NOR 0 vs 0.
  - Required: valid_o on 4 consecutive cycles.
  - Results: 0x80000000 (ovf=1), 0 (zero=1), 1, 0xFFFFFFFF.
- MUL 0xFFFFFFFF*0xFFFFFFFF.
  - Required: ready_o=0 for 32 cycles; valid_o exactly 33 edges after accept.
  - Outputs: hi_o=0xFFFFFFFE, result_o=0x00000001, overflow_o=1.
- MUL 6*7, then valid_i held high with an ADD during BUSY.
  - Required: the ADD is not taken until the valid_o cycle.
  - Outputs: result_o=42, hi_o=0, overflow_o=0; the ADD result follows one cycle later.
- Assert rst_i low at BUSY cycle 10 of a MUL.
  - Required: no valid_o, all outputs at reset values, and the next op completes normally.
- ALU_MC_DIV_EN defined:
  - DIVU 100/7: result_o=14, hi_o=2.
  - DIVU 9/0: result_o=0xFFFFFFFF, hi_o=9, overflow_o=1.
- ALU_MC_DIV_EN undefined: ctrl 5 gives result_o=0 one cycle after accept.
